// File: rtl/oai22_bank_pkg.sv
// oai22_bank_pkg: shared types and constants for the OAI22 lane bank and its self-test.
// Holds the self-test FSM state encoding, LFSR width, feedback taps and default seed.
// Also provides the LFSR next-state and OAI22 helper functions used by the RTL.
package oai22_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int                LFSR_W       = 16;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  // One Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic oai22(input logic a0, input logic a1, input logic b0, input logic b1);
    return ~((a0 | a1) & (b0 | b1));
  endfunction

endpackage

// File: rtl/oai22_bank_lfsr.sv
// oai22_bank_lfsr: 16-bit Fibonacci shift register with an XOR-in port (LFSR when din=0, MISR otherwise).
// Latency: one step per enabled clock; load has priority over step and restores INIT.
// Only built when OAI22_BANK_BIST_EN is defined; the bank has no self-test logic otherwise.
`ifdef OAI22_BANK_BIST_EN
module oai22_bank_lfsr
  import oai22_bank_pkg::*;
#(
  parameter logic [LFSR_W-1:0] INIT = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] din,
  output logic [LFSR_W-1:0] q
);

  // Register: reset/load to INIT, otherwise advance and fold in din when stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= INIT;
    end else if (load) begin
      q <= INIT;
    end else if (step) begin
      q <= lfsr_next(q) ^ din;
    end
  end

endmodule
`endif

// File: rtl/oai22_bank.sv
// oai22_bank: LANES independent registered OAI22 gates with an optional built-in self-test.
// Latency: Y one cycle after capture (EN=1); self-test takes NVEC+1 cycles after START is sampled.
// Self-test present only with OAI22_BANK_BIST_EN defined; otherwise START is ignored and BUSY/DONE/SIG are 0.
module oai22_bank
  import oai22_bank_pkg::*;
#(
  parameter int                LANES = 8,
  parameter int                NVEC  = 256,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              EN,
  input  logic [LANES-1:0]  A0,
  input  logic [LANES-1:0]  A1,
  input  logic [LANES-1:0]  B0,
  input  logic [LANES-1:0]  B1,
  output logic [LANES-1:0]  Y,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [LFSR_W-1:0] SIG
);

  logic [LANES-1:0] f_func;

  // Per-lane OAI22 of the pin operands
  always_comb begin
    f_func = '0;
    for (int i = 0; i < LANES; i++) begin
      f_func[i] = oai22(A0[i], A1[i], B0[i], B1[i]);
    end
  end

`ifdef OAI22_BANK_BIST_EN
  state_t            state;
  logic [16:0]       cnt;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] misr_q;
  logic [LANES-1:0]  f_bist;
  logic              run_entry;
  logic              lfsr_step;
  logic              misr_step;

  // A START outside RUN restarts the test; cnt counts vectors already captured into Y.
  assign run_entry = START && (state != ST_RUN);
  assign lfsr_step = (state == ST_RUN) && (cnt < 17'(NVEC));
  // Y holds a test result only from the second RUN edge on, so the MISR waits one cycle.
  assign misr_step = (state == ST_RUN) && (cnt != 17'd0);

  // Per-lane OAI22 with operands taken from consecutive LFSR bits, four per lane
  always_comb begin
    f_bist = '0;
    for (int i = 0; i < LANES; i++) begin
      f_bist[i] = oai22(lfsr_q[4'((4 * i) % 16)],     lfsr_q[4'((4 * i + 1) % 16)],
                        lfsr_q[4'((4 * i + 2) % 16)], lfsr_q[4'((4 * i + 3) % 16)]);
    end
  end

  oai22_bank_lfsr #(.INIT(SEED)) u_lfsr (
    .clk   (CLK),
    .rst_n (RN),
    .load  (run_entry),
    .step  (lfsr_step),
    .din   ('0),
    .q     (lfsr_q)
  );

  oai22_bank_lfsr #(.INIT(16'h0000)) u_misr (
    .clk   (CLK),
    .rst_n (RN),
    .load  (run_entry),
    .step  (misr_step),
    .din   (LFSR_W'(Y)),
    .q     (misr_q)
  );

  // Self-test sequencer with registered BUSY/DONE; START during RUN is ignored
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= ST_IDLE;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (cnt == 17'(NVEC)) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        default: begin
          if (START) begin
            state <= ST_RUN;
            cnt   <= '0;
            BUSY  <= 1'b1;
            DONE  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign SIG = DONE ? misr_q : '0;
`else
  logic [LFSR_W:0] cfg_unused;

  assign cfg_unused = {START, SEED ^ LFSR_W'(NVEC)};
  assign BUSY       = 1'b0;
  assign DONE       = 1'b0;
  assign SIG        = '0;
`endif

  // Lane result register: test vectors every cycle while running, else EN-gated pin results
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      Y <= '0;
    end
`ifdef OAI22_BANK_BIST_EN
    else if (state == ST_RUN) begin
      Y <= f_bist;
    end
`endif
    else if (EN) begin
      Y <= f_func;
    end
  end

endmodule
